// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared pc_sel and FSM state encodings for the PC target unit
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_RET    = 2'b11
  } pc_sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_target_unit_if.sv
// rtl/pc_target_unit_if.sv - control inputs and PC/RAS status outputs of the PC target unit
interface pc_target_unit_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic            stall;
  logic [1:0]      pc_sel;
  logic            branch_taken;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] trap_vec;
  logic            ras_push;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic [CW-1:0]   ras_count;

  modport master (
    output stall, pc_sel, branch_taken, imm, rs1_val, trap_vec, ras_push,
    input  pc, pc_plus4, target, misaligned, ras_count
  );

  modport slave (
    input  stall, pc_sel, branch_taken, imm, rs1_val, trap_vec, ras_push,
    output pc, pc_plus4, target, misaligned, ras_count
  );
endinterface

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack; a full push overwrites the oldest entry
module ras_stack #(
  parameter  int XLEN      = 32,
  parameter  int RAS_DEPTH = 4,
  localparam int PW        = $clog2(RAS_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic [CW-1:0]   count
);
  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_inc;
  logic [PW-1:0]   ptr_dec;
  logic            pop_ok;

  assign ptr_inc = ptr + PW'(1);
  assign ptr_dec = ptr - PW'(1);
  assign pop_ok  = pop && (count != '0);
  assign top     = mem[ptr];

  // Push+pop rewrites the current top in place instead of moving the pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[pop_ok ? ptr : ptr_inc] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && !pop_ok) begin
      ptr <= ptr_inc;
      if (count != CW'(RAS_DEPTH)) begin
        count <= count + CW'(1);
      end
    end else if (pop_ok && !push) begin
      ptr   <= ptr_dec;
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/pc_target_unit.sv
// rtl/pc_target_unit.sv - PC register, redirect target selection, misaligned-target trap FSM
module pc_target_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  pc_target_unit_if.slave     bus
);
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ras_top;
  pc_state_e       state;
  pc_sel_e         sel;
  logic            misaligned_q;
  logic            take;
  logic            trap_hit;
  logic            ras_push_en;
  logic            ras_pop_en;

  assign sel         = pc_sel_e'(bus.pc_sel);
  assign pc_plus4    = pc_q + XLEN'(4);
  assign jalr_sum    = bus.rs1_val + bus.imm;
  assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};

  always_comb begin
    target = pc_plus4;
    case (sel)
      PC_SEQ:    target = pc_plus4;
      PC_BRANCH: target = pc_q + bus.imm;
      PC_JALR:   target = jalr_target;
      PC_RET:    target = (bus.ras_count != '0) ? ras_top : jalr_target;
      default:   target = pc_plus4;
    endcase
  end

  assign take    = ((sel == PC_BRANCH) && bus.branch_taken) || (sel == PC_JALR) || (sel == PC_RET);
  assign next_pc = take ? target : pc_plus4;

  // Only RUN checks alignment, so a trap vector with bit1 set cannot re-trap on its own.
  assign trap_hit    = (state == ST_RUN) && next_pc[1];
  assign ras_push_en = !bus.stall && (state == ST_RUN) && !trap_hit && bus.ras_push;
  assign ras_pop_en  = !bus.stall && !trap_hit && (sel == PC_RET);

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push_en),
    .pop       (ras_pop_en),
    .push_data (pc_plus4),
    .top       (ras_top),
    .count     (bus.ras_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_VECTOR;
      state        <= ST_RUN;
      misaligned_q <= 1'b0;
    end else if (!bus.stall) begin
      case (state)
        ST_RUN: begin
          if (trap_hit) begin
            pc_q         <= bus.trap_vec;
            state        <= ST_TRAP;
            misaligned_q <= 1'b1;
          end else begin
            pc_q         <= next_pc;
            misaligned_q <= 1'b0;
          end
        end
        ST_TRAP: begin
          pc_q         <= next_pc;
          state        <= ST_RUN;
          misaligned_q <= 1'b0;
        end
        default: begin
          pc_q         <= next_pc;
          state        <= ST_RUN;
          misaligned_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.target     = target;
  assign bus.misaligned = misaligned_q;
endmodule

// File: tb/tb_pc_target_unit.sv
// tb/tb_pc_target_unit.sv - directed and randomized checks of pc_target_unit against a queue-based model
module tb_pc_target_unit;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_target_unit_if #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) bus ();

  pc_target_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_en  = 1'b0;
  logic [31:0] m_pc;
  bit          m_trap;
  logic [31:0] m_ras[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] m_target();
    logic [31:0] j;
    j = (bus.rs1_val + bus.imm) & 32'hFFFF_FFFE;
    case (bus.pc_sel)
      2'd0:    return m_pc + 32'd4;
      2'd1:    return m_pc + bus.imm;
      2'd2:    return j;
      default: return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : j;
    endcase
  endfunction

  function automatic logic [31:0] m_next();
    if ((bus.pc_sel == 2'd1 && bus.branch_taken) || bus.pc_sel[1]) return m_target();
    return m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc   = RV;
    m_trap = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_step();
    logic [31:0] npc;
    bit          pop;
    bit          push;
    if (!rst_n || bus.stall) return;
    npc = m_next();
    if (!m_trap && npc[1]) begin
      m_pc   = bus.trap_vec;
      m_trap = 1'b1;
      return;
    end
    pop  = (bus.pc_sel == 2'd3) && (m_ras.size() > 0);
    push = !m_trap && bus.ras_push;
    if (push && pop) m_ras[m_ras.size()-1] = m_pc + 32'd4;
    else if (pop) void'(m_ras.pop_back());
    else if (push) begin
      m_ras.push_back(m_pc + 32'd4);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end
    m_trap = 1'b0;
    m_pc   = npc;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", bus.pc, m_pc);
      check("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
      check("target", bus.target, m_target());
      check("misaligned", 32'(bus.misaligned), 32'(m_trap));
      check("ras_count", 32'(bus.ras_count), 32'(m_ras.size()));
    end
  end

  task automatic set_in(input logic st, input logic [1:0] sel, input logic bt,
                        input logic [31:0] imm_v, input logic [31:0] rs1_v, input logic push);
    bus.stall        = st;
    bus.pc_sel       = sel;
    bus.branch_taken = bt;
    bus.imm          = imm_v;
    bus.rs1_val      = rs1_v;
    bus.ras_push     = push;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  logic [31:0] ret_tgt [5] = '{32'h14, 32'h10, 32'hC, 32'h8, 32'h40};
  logic [31:0] ret_cnt [5] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};

  initial begin
    bus.trap_vec = 32'h80;
    set_in(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    model_reset();
    #3;
    check("reset_pc", bus.pc, RV);
    check("reset_misaligned", 32'(bus.misaligned), 32'h0);
    check("reset_ras_count", 32'(bus.ras_count), 32'h0);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    check("seq_pc0", bus.pc, 32'h0);
    tick(); check("seq_pc1", bus.pc, 32'h4);
    tick(); check("seq_pc2", bus.pc, 32'h8);
    tick(); check("seq_pc3", bus.pc, 32'hC);

    set_in(1'b0, 2'd2, 1'b0, 32'h0, 32'h100, 1'b0); tick();
    check("jalr_to_100", bus.pc, 32'h100);
    set_in(1'b0, 2'd1, 1'b1, 32'hFFFF_FFF0, 32'h0, 1'b0); #1;
    check("branch_target", bus.target, 32'hF0);
    tick(); check("branch_taken_pc", bus.pc, 32'hF0);
    set_in(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 1'b0); tick();
    check("branch_back_pc", bus.pc, 32'h100);
    set_in(1'b0, 2'd1, 1'b0, 32'h40, 32'h0, 1'b0); tick();
    check("branch_not_taken_pc", bus.pc, 32'h104);

    set_in(1'b0, 2'd2, 1'b0, 32'h4, 32'h2001, 1'b0); tick();
    check("jalr_bit0_pc", bus.pc, 32'h2004);
    check("jalr_no_trap", 32'(bus.misaligned), 32'h0);
    set_in(1'b0, 2'd2, 1'b0, 32'h0, 32'h2002, 1'b0); tick();
    check("trap_pc", bus.pc, 32'h80);
    check("trap_misaligned", 32'(bus.misaligned), 32'h1);
    set_in(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0); tick();
    check("trap_one_cycle", 32'(bus.misaligned), 32'h0);
    check("after_trap_pc", bus.pc, 32'h84);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1); tick();
    end
    check("push5_pc", bus.pc, 32'h14);
    check("push5_count", 32'(bus.ras_count), 32'd4);
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 2'd3, 1'b0, 32'h0, 32'h40, 1'b0); #1;
      check("ret_target", bus.target, ret_tgt[i]);
      tick();
      check("ret_pc", bus.pc, ret_tgt[i]);
      check("ret_count", 32'(bus.ras_count), ret_cnt[i]);
    end

    set_in(1'b0, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0); tick();
    check("top_pc", bus.pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", bus.pc_plus4, 32'h0);
    set_in(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1); tick();
    check("wrap_pc", bus.pc, 32'h0);
    check("wrap_push_count", 32'(bus.ras_count), 32'd1);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 2'd3, 1'b1, 32'h123, 32'h2002, 1'b1); tick();
      check("stall_pc", bus.pc, 32'h0);
      check("stall_count", 32'(bus.ras_count), 32'd1);
    end
    set_in(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0); tick();
    check("post_stall_pc", bus.pc, 32'h4);

    set_in(1'b0, 2'd2, 1'b0, 32'h0, 32'h2002, 1'b0); tick();
    check("trap2_misaligned", 32'(bus.misaligned), 32'h1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_in_trap_pc", bus.pc, RV);
    check("rst_in_trap_misaligned", 32'(bus.misaligned), 32'h0);
    rst_n = 1'b1;
    set_in(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0); tick();
    check("rst_release_pc", bus.pc, RV + 32'd4);
    check("rst_release_run", 32'(bus.misaligned), 32'h0);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      bus.trap_vec = ($urandom_range(0, 7) == 0) ? 32'h0000_0202 : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      set_in($urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 63)) * 32'd2 - 32'd64, 32'($urandom_range(0, 4095)),
             $urandom_range(0, 2) == 0);
      tick();
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_target_unit.md
PC_TARGET_UNIT -- requirements
Module: pc_target_unit

Interface
REQ-001 Parameter XLEN, default 32: address/data width in bits (min 8).
REQ-002 Parameter RESET_VECTOR, default 0: PC value loaded at reset.
REQ-003 Parameter RAS_DEPTH, default 4: return-address-stack entries (power of 2, min 2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 stall  input  1  hold PC and RAS when high.
REQ-007 pc_sel  input  2  00 sequential, 01 branch, 10 jalr, 11 return.
REQ-008 branch_taken  input  1  qualifies pc_sel=01.
REQ-009 imm  input  XLEN  sign-extended immediate.
REQ-010 rs1_val  input  XLEN  register operand for jalr/return fallback.
REQ-011 trap_vec  input  XLEN  misaligned-target trap handler address.
REQ-012 ras_push  input  1  push pc_plus4 onto RAS (call).
REQ-013 pc  output  XLEN  current PC.
REQ-014 pc_plus4  output  XLEN  pc+4, combinational.
REQ-015 target  output  XLEN  computed redirect target, combinational.
REQ-016 misaligned  output  1  one-cycle trap indication.
REQ-017 ras_count  output  clog2(RAS_DEPTH)+1  valid RAS entries.

Function
REQ-018 pc_plus4 SHALL equal pc+4 modulo 2^XLEN (wrap at top of space, no flag).
REQ-019 target SHALL be: pc+imm for 01; (rs1_val+imm) with bit0 cleared for 10; RAS top for 11 when ras_count>0, else jalr target; pc_plus4 for 00; all modulo 2^XLEN.
REQ-020 Next PC SHALL be target when (pc_sel=01 and branch_taken) or pc_sel in {10,11}; else pc_plus4.
REQ-021 FSM states RUN and TRAP; reset enters RUN.
REQ-022 In RUN with stall=0, if selected next PC has bit1 set, SHALL load pc<=trap_vec, enter TRAP, leave RAS unchanged; otherwise load next PC.
REQ-023 In TRAP, misaligned SHALL be 1; next edge returns to RUN unconditionally and PC advances per REQ-020 (stall honoured).
REQ-024 misaligned SHALL be 0 in RUN; trap_vec bit1 set is not re-checked.
REQ-025 stall=1 SHALL hold pc, FSM state, and RAS; ras_push/return ignored that cycle.
REQ-026 Push (ras_push=1, not stalled, RUN, no trap) SHALL store pc_plus4 at top; ras_count increments, saturating at RAS_DEPTH; on full, oldest entry overwritten.
REQ-027 Return (pc_sel=11, not stalled, no trap) with ras_count>0 SHALL pop; with ras_count=0 SHALL not pop, count stays 0.
REQ-028 Simultaneous push and pop SHALL replace top with pc_plus4; ras_count unchanged.
REQ-029 Latency: redirect visible on pc one cycle after the selecting cycle.

Reset
REQ-030 rst_n low SHALL immediately force pc=RESET_VECTOR, state RUN, misaligned=0, ras_count=0; RAS storage contents need not reset.
REQ-031 Reset asserted mid-TRAP SHALL abandon the trap; first cycle after release is RUN at RESET_VECTOR.

Structure
REQ-032 pc_sel encodings and FSM state encodings SHALL live in a shared package pc_pkg.
REQ-033 RAS SHALL be one sub-module ras_stack (parameter RAS_DEPTH, XLEN; push/pop/top/count, circular pointer).
REQ-034 Target adders SHALL be plain XLEN-bit adds; no carry-out port.

Verification
REQ-035 Reset release, pc_sel=00 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC.
REQ-036 pc=0x100, pc_sel=01, branch_taken=1, imm=0xFFFFFFF0 -> pc=0xF0 next cycle; branch_taken=0 -> pc=0x104.
REQ-037 pc_sel=10, rs1_val=0x2001, imm=0x4 -> pc=0x2004; rs1_val=0x2002, imm=0 -> pc=trap_vec, misaligned=1 exactly one cycle.
REQ-038 RAS_DEPTH=4: push 5 times at pc 0x0..0x10 then return 5 times -> targets 0x14,0x10,0xC,0x8, then jalr fallback; ras_count 4,3,2,1,0,0.
REQ-039 pc=0xFFFFFFFC, pc_sel=00 -> pc=0x0; stall held 3 cycles mid-sequence -> pc and ras_count unchanged.
REQ-040 rst_n pulsed low during TRAP -> pc=RESET_VECTOR immediately, misaligned=0.
